fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of FIFO read data and stream data.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning words per burst; legal range 2..256.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of word_count.
REQ-004 SHALL have port rclk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rrst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, permits FIFO draining.
REQ-007 SHALL have port fifo_empty, input, 1, FIFO read-side empty flag.
REQ-008 SHALL have port fifo_data, input, DATA_WIDTH, FIFO head word, valid while fifo_empty=0.
REQ-009 SHALL have port fifo_r_en, output, 1, FIFO pop strobe.
REQ-010 SHALL have port m_data, output, DATA_WIDTH, stream data.
REQ-011 SHALL have port m_valid, output, 1, stream valid.
REQ-012 SHALL have port m_last, output, 1, last word of burst.
REQ-013 SHALL have port m_ready, input, 1, downstream ready.
REQ-014 SHALL have port busy, output, 1, block active or holding data.
REQ-015 SHALL have port word_count, output, CNT_WIDTH, count of completed stream transfers.

Function
REQ-016 SHALL hold a 2-entry output buffer (occupancy occ 0..2), each entry = data + last tag, FIFO order.
REQ-017 SHALL drive fifo_r_en = pop_state && !fifo_empty && occ<2, combinationally, with pop_state true in BURST or DRAIN; occ is the registered value at cycle start.
REQ-018 SHALL capture fifo_data into the buffer tail on the same rclk edge where fifo_r_en=1 (zero-latency read data).
REQ-019 SHALL count pops in burst_cnt (0..BURST_LEN-1); tag a popped word last when burst_cnt==BURST_LEN-1; wrap burst_cnt to 0 after that pop.
REQ-020 SHALL drive m_valid = (occ!=0), m_data/m_last from buffer head; transfer = m_valid && m_ready.
REQ-021 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-022 SHALL, on simultaneous pop and transfer, keep occ unchanged and preserve order; occ=1 steady state gives one word per cycle.
REQ-023 SHALL implement FSM states IDLE, BURST, DRAIN.
REQ-024 IDLE: no pops; -> BURST when enable=1.
REQ-025 BURST: pops allowed; enable=0 with burst_cnt==0 -> IDLE; enable=0 with burst_cnt!=0 -> DRAIN.
REQ-026 DRAIN: pops allowed regardless of enable; on the pop of the last-tagged word -> BURST if enable=1, else IDLE.
REQ-027 SHALL never emit a partial burst due to enable deassertion; fifo_empty stalls only delay the burst.
REQ-028 SHALL increment word_count by 1 per transfer, wrapping modulo 2^CNT_WIDTH.
REQ-029 SHALL drive busy = (state!=IDLE) || (occ!=0).
REQ-030 SHALL not drop or duplicate any word under any combination of fifo_empty, enable and m_ready.

Reset
REQ-031 SHALL, while rrst_n=0 (asynchronously), force state IDLE, occ 0, burst_cnt 0, word_count 0, m_data 0, m_valid 0, m_last 0, busy 0, fifo_r_en 0.
REQ-032 SHALL discard buffered words on reset mid-operation; the first burst after reset starts at burst_cnt 0.

Verification
REQ-033 BURST_LEN=4, FIFO holds 0x10..0x17, enable=1, m_ready=1 -> 8 transfers in order, one per cycle after first, m_last on 0x13 and 0x17, word_count=8, busy=0 after drain with enable=0.
REQ-034 m_ready=0 for 5 cycles with data available -> occ=2, fifo_r_en=0, m_data held at first word; m_ready=1 -> all words delivered once, in order.
REQ-035 enable=0 after 2 pops of a 4-word burst -> exactly 2 further pops, m_last on 4th, FSM BURST->DRAIN->IDLE, no further pops.
REQ-036 fifo_empty toggled every other cycle mid-burst -> fifo_r_en never 1 while fifo_empty=1, burst_cnt advances only on pops, m_last placement unchanged.
REQ-037 rrst_n pulsed low mid-burst with occ=2 -> all outputs 0 immediately, no fifo_r_en; after release and enable=1 next m_last falls on 4th popped word.
REQ-038 CNT_WIDTH=4, 17 transfers -> word_count reads 1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Drains a zero-latency FIFO into a valid/ready stream in fixed-length bursts,
// through a 2-entry skid buffer so that a stalled consumer never loses a word.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [1:0]            occ_r, occ_nxt_s;
    logic [DATA_WIDTH-1:0] head_data_r, head_data_nxt_s;
    logic [DATA_WIDTH-1:0] tail_data_r, tail_data_nxt_s;
    logic                  head_last_r, head_last_nxt_s;
    logic                  tail_last_r, tail_last_nxt_s;
    logic [BC_W-1:0]       burst_cnt_r, burst_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]  word_count_r;
    logic                  m_valid_r;
    logic                  busy_r;
    logic                  pop_s;
    logic                  xfer_s;
    logic                  last_tag_s;

    // Pop and transfer qualification from the occupancy held at cycle start.
    always_comb begin
        pop_s      = 1'b0;
        xfer_s     = 1'b0;
        last_tag_s = 1'b0;
        if ((state_r != ST_IDLE) && !fifo_empty && (occ_r < 2'd2)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if ((occ_r != 2'd0) && m_ready) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
        if (burst_cnt_r == BC_LAST) begin
            last_tag_s = 1'b1;
        end else begin
            last_tag_s = 1'b0;
        end
    end

    // Skid buffer next state: push at tail, pop at head, order preserved.
    always_comb begin
        occ_nxt_s       = occ_r;
        head_data_nxt_s = head_data_r;
        head_last_nxt_s = head_last_r;
        tail_data_nxt_s = tail_data_r;
        tail_last_nxt_s = tail_last_r;
        case ({pop_s, xfer_s})
            2'b10: begin
                occ_nxt_s = occ_r + 2'd1;
                if (occ_r == 2'd0) begin
                    head_data_nxt_s = fifo_data;
                    head_last_nxt_s = last_tag_s;
                end else begin
                    tail_data_nxt_s = fifo_data;
                    tail_last_nxt_s = last_tag_s;
                end
            end
            2'b01: begin
                occ_nxt_s       = occ_r - 2'd1;
                head_data_nxt_s = tail_data_r;
                head_last_nxt_s = tail_last_r;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    head_data_nxt_s = fifo_data;
                    head_last_nxt_s = last_tag_s;
                end else begin
                    head_data_nxt_s = tail_data_r;
                    head_last_nxt_s = tail_last_r;
                    tail_data_nxt_s = fifo_data;
                    tail_last_nxt_s = last_tag_s;
                end
            end
            default: begin
                occ_nxt_s = occ_r;
            end
        endcase
    end

    // Burst position advances only on an actual pop.
    always_comb begin
        burst_cnt_nxt_s = burst_cnt_r;
        if (pop_s) begin
            if (last_tag_s) begin
                burst_cnt_nxt_s = {BC_W{1'b0}};
            end else begin
                burst_cnt_nxt_s = burst_cnt_r + BC_W'(1);
            end
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // FSM next state; leaving BURST looks at the count after this cycle's pop
    // so a word popped as enable drops still gets its full burst.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (enable) begin
                    state_nxt_s = ST_BURST;
                end else if (burst_cnt_nxt_s == {BC_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && last_tag_s) begin
                    state_nxt_s = enable ? ST_BURST : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, counters and registered status outputs.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_r        <= 2'd0;
            head_data_r  <= {DATA_WIDTH{1'b0}};
            head_last_r  <= 1'b0;
            tail_data_r  <= {DATA_WIDTH{1'b0}};
            tail_last_r  <= 1'b0;
            burst_cnt_r  <= {BC_W{1'b0}};
            word_count_r <= {CNT_WIDTH{1'b0}};
            m_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            occ_r        <= occ_nxt_s;
            head_data_r  <= head_data_nxt_s;
            head_last_r  <= head_last_nxt_s;
            tail_data_r  <= tail_data_nxt_s;
            tail_last_r  <= tail_last_nxt_s;
            burst_cnt_r  <= burst_cnt_nxt_s;
            word_count_r <= xfer_s ? (word_count_r + CNT_WIDTH'(1)) : word_count_r;
            m_valid_r    <= (occ_nxt_s != 2'd0);
            busy_r       <= (state_nxt_s != ST_IDLE) || (occ_nxt_s != 2'd0);
        end
    end

    assign fifo_r_en  = pop_s;
    assign m_data     = head_data_r;
    assign m_last     = head_last_r;
    assign m_valid    = m_valid_r;
    assign busy       = busy_r;
    assign word_count = word_count_r;

endmodule
